// File: rtl/usb_data_buffer_if.sv
// usb_data_buffer_if: AHB and USB push/pop signals of the shared byte FIFO.
interface usb_data_buffer_if #(parameter int DEPTH = 64);
    localparam int OW = $clog2(DEPTH) + 1;
    logic          clear;
    logic          store_tx_data;
    logic [31:0]   tx_data;
    logic          get_rx_data;
    logic [1:0]    data_size;
    logic [31:0]   rx_data;
    logic          store_rx_packet_data;
    logic [7:0]    rx_packet_data;
    logic          get_tx_packet_data;
    logic [7:0]    tx_packet_data;
    logic [OW-1:0] buffer_occupancy;
    logic          overrun;
    logic          underrun;
    modport slave (
        input  clear, store_tx_data, tx_data, get_rx_data, data_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
    );
    modport master (
        output clear, store_tx_data, tx_data, get_rx_data, data_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
    );
endinterface

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: byte-wide circular FIFO shared by the AHB slave (1/2/4-byte
// words) and the USB packet engines (single bytes), with overrun/underrun pulses.
module usb_data_buffer #(
    parameter int DEPTH = 64
) (
    input logic clk,
    input logic rst,
    usb_data_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [2:0]    n, pop_req, push_req, p, ahb_p;
    logic [AW+1:0] occ_after;
    logic          ahb_push, ahb_pop, usb_pop, usb_drop, accept, ovr_next, und_next;
    logic [31:0]   rx;
    logic          ovr_q, und_q;
    always_comb begin
        n         = bus.data_size == 2'b00 ? 3'd1 : bus.data_size == 2'b01 ? 3'd2 :
                    bus.data_size == 2'b10 ? 3'd4 : 3'd0;
        ahb_push  = bus.store_tx_data && n != 3'd0;
        ahb_pop   = bus.get_rx_data && n != 3'd0;
        usb_pop   = bus.get_tx_packet_data && !ahb_pop;
        pop_req   = ahb_pop ? n : {2'b00, usb_pop};
        p         = (AW+1)'(pop_req) > occ ? occ[2:0] : pop_req;
        ahb_p     = (AW+1)'(n) > occ ? occ[2:0] : n;
        push_req  = ahb_push ? n : {2'b00, bus.store_rx_packet_data};
        usb_drop  = ahb_push && bus.store_rx_packet_data;
        // Push acceptance sees the room freed by a same-cycle pop.
        occ_after = (AW+2)'(occ) - (AW+2)'(p) + (AW+2)'(push_req);
        accept    = occ_after <= (AW+2)'(DEPTH);
        ovr_next  = usb_drop || (push_req != 3'd0 && !accept);
        und_next  = (AW+1)'(pop_req) > occ;
        rx        = '0;
        for (int k = 0; k < 4; k++)
            if (k < int'(ahb_p)) rx[8*k +: 8] = mem[rd_ptr + AW'(k)];
    end
    always_ff @(posedge clk)
        if (!rst && !bus.clear && accept)
            for (int k = 0; k < 4; k++)
                if (k < int'(push_req))
                    mem[wr_ptr + AW'(k)] <= ahb_push ? bus.tx_data[8*k +: 8] : bus.rx_packet_data;
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovr_q  <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(p);
            wr_ptr <= accept ? wr_ptr + AW'(push_req) : wr_ptr;
            occ    <= accept ? occ_after[AW:0] : occ - (AW+1)'(p);
            ovr_q  <= ovr_next;
            und_q  <= und_next;
        end
    end
    assign bus.rx_data          = rx;
    assign bus.tx_packet_data   = occ != '0 ? mem[rd_ptr] : 8'h00;
    assign bus.buffer_occupancy = occ;
    assign bus.overrun          = ovr_q;
    assign bus.underrun         = und_q;
endmodule
